// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// pcsrc_t encodes the fetch-stage next-PC source selected by the control unit.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    PCSRC_JR  = 3'd0,
    PCSRC_J   = 3'd1,
    PCSRC_BR  = 3'd2,
    PCSRC_SEQ = 3'd3,
    PCSRC_JAL = 3'd4,
    PCSRC_RET = 3'd5
  } pcsrc_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular-buffer return-address stack.
// ptr names the next free slot, so top is the slot just below it.
module return_addr_stack #(
  parameter  int PC_W      = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int PTR_W     = $clog2(RAS_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [PC_W-1:0]  wdata,
  output logic [PC_W-1:0]  top,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  entries_q [RAS_DEPTH];
  logic [PC_W-1:0]  entries_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // When full, ptr already sits on the oldest entry, so a push overwrites it.
  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    if (clr) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push) begin
      entries_d[ptr_q] = wdata;
      ptr_d            = ptr_q + PTR_W'(1);
      if (count_q != FULL) count_d = count_q + CNT_W'(1);
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign top   = entries_q[ptr_q - PTR_W'(1)];
  assign count = count_q;

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter: next-PC mux, PC and ras_pred flops, and a
// return-address stack predicting JR $31 (RET) targets.
module pc_ras_unit
  import cpu_types_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] PC_INIT   = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         pc_en,
  input  logic [2:0]                   pc_src,
  input  logic                         br_taken,
  input  logic [PC_W-1:0]              rdat1,
  input  logic [25:0]                  immediate26,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         ras_clr,
  output logic [PC_W-1:0]              imemaddr,
  output logic [PC_W-1:0]              pc_plus4,
  output logic                         ras_pred,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  logic [PC_W-1:0]            pc_q, pc_d;
  logic                       ras_pred_q, ras_pred_d;
  logic [PC_W-1:0]            ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_cnt;
  logic [PC_W-1:0]            br_off, j_target;
  logic                       advance, ras_push, ras_pop, ras_clear;

  assign pc_plus4 = pc_q + PC_W'(4);
  assign br_off   = {{(PC_W-18){immediate26[15]}}, immediate26[15:0], 2'b00};
  assign j_target = ((pc_plus4 >> 28) << 28) | PC_W'({immediate26, 2'b00});

  // A redirect or stall freezes the RAS; only an advancing fetch may touch it.
  assign advance   = pc_en && !redirect;
  assign ras_push  = advance && (pc_src == PCSRC_JAL);
  assign ras_pop   = advance && (pc_src == PCSRC_RET);
  assign ras_clear = advance && ras_clr;

  return_addr_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (ras_push),
    .pop   (ras_pop),
    .clr   (ras_clear),
    .wdata (pc_plus4),
    .top   (ras_top),
    .count (ras_cnt)
  );

  always_comb begin
    pc_d       = pc_q;
    ras_pred_d = ras_pred_q;
    if (redirect) begin
      pc_d       = redirect_pc;
      ras_pred_d = 1'b0;
    end else if (pc_en) begin
      ras_pred_d = 1'b0;
      case (pc_src)
        PCSRC_JR:             pc_d = rdat1;
        PCSRC_J, PCSRC_JAL:   pc_d = j_target;
        PCSRC_BR:             pc_d = br_taken ? pc_plus4 + br_off : pc_plus4;
        PCSRC_RET: begin
          if (ras_cnt != '0) begin
            pc_d       = ras_top;
            ras_pred_d = 1'b1;
          end else begin
            pc_d = rdat1;
          end
        end
        default:              pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q       <= PC_INIT;
      ras_pred_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ras_pred_q <= ras_pred_d;
    end
  end

  assign imemaddr  = pc_q;
  assign ras_pred  = ras_pred_q;
  assign ras_count = ras_cnt;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_pc_ras_unit;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en;
  logic [2:0]  pc_src;
  logic        br_taken;
  logic [31:0] rdat1;
  logic [25:0] immediate26;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ras_clr;
  logic [31:0] imemaddr;
  logic [31:0] pc_plus4;
  logic        ras_pred;
  logic [2:0]  ras_count;

  pc_ras_unit #(.PC_W(32), .PC_INIT(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .pc_src(pc_src), .br_taken(br_taken),
    .rdat1(rdat1), .immediate26(immediate26), .redirect(redirect),
    .redirect_pc(redirect_pc), .ras_clr(ras_clr), .imemaddr(imemaddr),
    .pc_plus4(pc_plus4), .ras_pred(ras_pred), .ras_count(ras_count)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic        check_en = 1'b0;
  logic [31:0] m_pc;
  logic        m_pred;
  logic [31:0] m_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("cmp_imemaddr", imemaddr, m_pc);
      checkOutput("cmp_pc_plus4", pc_plus4, m_pc + 32'd4);
      checkOutput("cmp_ras_pred", {31'b0, ras_pred}, {31'b0, m_pred});
      checkOutput("cmp_ras_count", {29'b0, ras_count}, m_q.size());
    end
  end

  task automatic modelReset();
    m_pc   = 32'h0;
    m_pred = 1'b0;
    m_q.delete();
  endtask

  // Drives one cycle, predicts the next state from the rules, then waits
  // until the following negedge so outputs can be checked.
  task automatic applyStimulus(input logic en, input logic [2:0] src, input logic bt,
                               input logic [31:0] rd, input logic [25:0] imm,
                               input logic redir, input logic [31:0] rpc, input logic clr);
    logic [31:0] n_pc, plus4;
    logic        n_pred;
    logic [31:0] nq[$];
    pc_en = en; pc_src = src; br_taken = bt; rdat1 = rd; immediate26 = imm;
    redirect = redir; redirect_pc = rpc; ras_clr = clr;
    plus4  = m_pc + 32'd4;
    n_pc   = m_pc;
    n_pred = m_pred;
    nq     = m_q;
    if (redir) begin
      n_pc = rpc; n_pred = 1'b0;
    end else if (en) begin
      n_pred = 1'b0;
      case (src)
        3'd0: n_pc = rd;
        3'd1, 3'd4: n_pc = {plus4[31:28], imm, 2'b00};
        3'd2: n_pc = bt ? plus4 + {{14{imm[15]}}, imm[15:0], 2'b00} : plus4;
        3'd5: if (m_q.size() > 0) begin n_pc = m_q[$]; n_pred = 1'b1; end
              else n_pc = rd;
        default: n_pc = plus4;
      endcase
      if (clr) nq.delete();
      else if (src == 3'd4) begin
        nq.push_back(plus4);
        if (nq.size() > DEPTH) void'(nq.pop_front());
      end else if (src == 3'd5 && nq.size() > 0) void'(nq.pop_back());
    end
    @(posedge CLK);
    m_pc = n_pc; m_pred = n_pred; m_q = nq;
    @(negedge CLK);
  endtask

  task automatic seq(); applyStimulus(1, 3'd3, 0, 0, 0, 0, 0, 0); endtask
  task automatic redir(input logic [31:0] a); applyStimulus(0, 3'd3, 0, 0, 0, 1, a, 0); endtask
  task automatic jal(input logic [31:0] tgt); applyStimulus(1, 3'd4, 0, 0, tgt[27:2], 0, 0, 0); endtask
  task automatic ret(input logic [31:0] rd); applyStimulus(1, 3'd5, 0, rd, 0, 0, 0, 0); endtask

  initial begin
    nRST = 1'b0; pc_en = 0; pc_src = 3'd3; br_taken = 0; rdat1 = 0; immediate26 = 0;
    redirect = 0; redirect_pc = 0; ras_clr = 0;
    modelReset();
    @(negedge CLK); @(negedge CLK);
    #2 nRST = 1'b1;
    check_en = 1'b1;
    checkOutput("reset_pc", imemaddr, 32'h0);
    checkOutput("reset_plus4", pc_plus4, 32'h4);
    checkOutput("reset_count", {29'b0, ras_count}, 32'h0);

    // Sequential fetch
    seq(); checkOutput("t1_pc4", imemaddr, 32'h4);
    seq(); checkOutput("t1_pc8", imemaddr, 32'h8);
    seq(); checkOutput("t1_pcC", imemaddr, 32'hC);

    // Branches and stall
    redir(32'h40);
    applyStimulus(1, 3'd2, 1, 0, 26'h000FFFE, 0, 0, 0);
    checkOutput("t2_br_taken", imemaddr, 32'h3C);
    redir(32'h40);
    applyStimulus(1, 3'd2, 0, 0, 26'h000FFFE, 0, 0, 0);
    checkOutput("t2_br_not", imemaddr, 32'h44);
    redir(32'h40);
    applyStimulus(0, 3'd3, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_stall", imemaddr, 32'h40);

    // JAL then RET
    redir(32'h100);
    applyStimulus(1, 3'd4, 0, 0, 26'h40, 0, 0, 0);
    checkOutput("t3_jal_pc", imemaddr, 32'h100);
    checkOutput("t3_jal_cnt", {29'b0, ras_count}, 32'd1);
    ret(32'hDEAD);
    checkOutput("t3_ret_pc", imemaddr, 32'h104);
    checkOutput("t3_ret_pred", {31'b0, ras_pred}, 32'd1);
    checkOutput("t3_ret_cnt", {29'b0, ras_count}, 32'd0);

    // Overflow: 5 JALs at 0x1000..0x5000, then 5 RETs
    redir(32'h1000);
    for (int i = 0; i < 5; i++) jal(32'(i + 2) << 12);
    checkOutput("t4_full_cnt", {29'b0, ras_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      ret(32'hBEEF0);
      checkOutput("t4_ret_pc", imemaddr, (32'(5 - i) << 12) + 32'd4);
      checkOutput("t4_ret_cnt", {29'b0, ras_count}, 32'(3 - i));
    end
    ret(32'hBEEF0);
    checkOutput("t4_empty_pc", imemaddr, 32'hBEEF0);
    checkOutput("t4_empty_pred", {31'b0, ras_pred}, 32'd0);
    checkOutput("t4_empty_cnt", {29'b0, ras_count}, 32'd0);

    // Redirect beats stall/JAL; clear beats pop but PC uses old top
    redir(32'h600);
    jal(32'h800);
    applyStimulus(0, 3'd4, 0, 0, 26'h123, 1, 32'h300, 0);
    checkOutput("t5_redir_pc", imemaddr, 32'h300);
    checkOutput("t5_redir_cnt", {29'b0, ras_count}, 32'd1);
    applyStimulus(1, 3'd5, 0, 32'h77, 0, 0, 0, 1);
    checkOutput("t5_clr_pc", imemaddr, 32'h604);
    checkOutput("t5_clr_cnt", {29'b0, ras_count}, 32'd0);

    // Async reset with count=3, PC=0x200, ras_pred=1
    redir(32'h1F0);
    jal(32'h1F4); jal(32'h1F8); jal(32'h1FC); jal(32'h1000);
    ret(32'h0);
    checkOutput("t6_pre_pc", imemaddr, 32'h200);
    checkOutput("t6_pre_cnt", {29'b0, ras_count}, 32'd3);
    #2 nRST = 1'b0;
    modelReset();
    #1;
    checkOutput("t6_rst_pc", imemaddr, 32'h0);
    checkOutput("t6_rst_cnt", {29'b0, ras_count}, 32'd0);
    checkOutput("t6_rst_pred", {31'b0, ras_pred}, 32'd0);
    @(negedge CLK);
    #2 nRST = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic        en, rd_i, clr;
      logic [2:0]  src;
      en   = ($urandom_range(0, 7) != 0);
      rd_i = ($urandom_range(0, 15) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      src  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) src = 3'd4;
      applyStimulus(en, src, 1'($urandom), $urandom & 32'hFFFF_FFFC, 26'($urandom),
                    rd_i, $urandom & 32'hFFFF_FFFC, clr);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
